// File: rtl/ram_pkg.sv
// Shared types and helpers for the banked synchronous RAM.
// Helpers work on the widest supported vectors; callers cast to their own widths.
package ram_pkg;

   localparam int RAM_MAX_ADDR  = 64;
   localparam int RAM_MAX_DATA  = 256;
   localparam int RAM_MAX_LANES = RAM_MAX_DATA / 8;

   typedef enum logic {RAM_CLEAR, RAM_READY} ram_state_t;

   // Drops the byte-offset bits and wraps the address modulo the array depth.
   function automatic logic [RAM_MAX_ADDR-1:0] word_index(
      input logic [RAM_MAX_ADDR-1:0] addr,
      input int                      lane_bits,
      input int                      idx_bits
   );
      logic [RAM_MAX_ADDR-1:0] mask;
      mask = (RAM_MAX_ADDR'(1) << idx_bits) - RAM_MAX_ADDR'(1);
      return (addr >> lane_bits) & mask;
   endfunction

   function automatic logic [RAM_MAX_DATA-1:0] merge_bytes(
      input logic [RAM_MAX_DATA-1:0]  old_word,
      input logic [RAM_MAX_DATA-1:0]  new_word,
      input logic [RAM_MAX_LANES-1:0] be
   );
      logic [RAM_MAX_DATA-1:0] res;
      res = old_word;
      for (int k = 0; k < RAM_MAX_LANES; k++) begin
         if (be[k]) res[8*k +: 8] = new_word[8*k +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/ram_lane.sv
// One byte lane of the banked RAM: a single write port and two registered read ports.
// Reads return the contents from before a same-edge write; forwarding is handled above.
module ram_lane #(
   parameter  int DEPTH = 1024,
   localparam int IDX_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we_i,
   input  logic [IDX_W-1:0] waddr_i,
   input  logic [7:0]       wdata_i,
   input  logic             re_i,
   input  logic [IDX_W-1:0] raddr_a_i,
   input  logic [IDX_W-1:0] raddr_b_i,
   output logic [7:0]       rdata_a_o,
   output logic [7:0]       rdata_b_o
);

   (* ram_style = "block" *) logic [7:0] mem_q [DEPTH];

   logic [7:0] rdata_a_q;
   logic [7:0] rdata_b_q;

   always_ff @(posedge clk) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
      if (re_i) begin
         rdata_a_q <= mem_q[raddr_a_i];
         rdata_b_q <= mem_q[raddr_b_i];
      end
   end

   assign rdata_a_o = rdata_a_q;
   assign rdata_b_o = rdata_b_q;

endmodule

// File: rtl/ram_banked_sync.sv
// Byte-lane RAM with registered data and fetch read ports, write-first forwarding
// and a zero-fill sequencer that runs after every reset before requests are accepted.
//
// state     | meaning
// RAM_CLEAR | writing zero to word[cnt_q] each enabled cycle; requests dropped
// RAM_READY | normal operation until the next reset
module ram_banked_sync
   import ram_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 1024
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    clk_en,
   output logic                    o_ready,
   input  logic                    i_read_req,
   input  logic [ADDR_WIDTH-1:0]   i_read_addr,
   output logic                    o_read_valid,
   output logic [DATA_WIDTH-1:0]   o_read_data,
   input  logic                    i_fetch_req,
   input  logic [ADDR_WIDTH-1:0]   i_fetch_addr,
   output logic                    o_fetch_valid,
   output logic [DATA_WIDTH-1:0]   o_fetch_data,
   input  logic                    i_write_enable,
   input  logic [DATA_WIDTH/8-1:0] i_byte_enable,
   input  logic [ADDR_WIDTH-1:0]   i_write_addr,
   input  logic [DATA_WIDTH-1:0]   i_write_data
);

   localparam int NUM_LANES = DATA_WIDTH / 8;
   localparam int LANE_BITS = $clog2(NUM_LANES);
   localparam int IDX_W     = $clog2(DEPTH);

   typedef logic [IDX_W-1:0] idx_t;

   ram_state_t state_q, state_d;
   idx_t       cnt_q, cnt_d;

   idx_t rd_idx, fe_idx, wr_idx, lane_waddr;
   logic clearing, clear_go, accept, wr_go, rd_go, fe_go;
   logic [NUM_LANES-1:0]  lane_we;
   logic [DATA_WIDTH-1:0] lane_wdata;
   logic [DATA_WIDTH-1:0] raw_rd, raw_fe, merged_rd, merged_fe;

   logic                  rvalid_q, fvalid_q, rhit_q, fhit_q;
   logic [DATA_WIDTH-1:0] fwd_data_q;
   logic [NUM_LANES-1:0]  fwd_be_q;

   assign rd_idx = idx_t'(word_index(RAM_MAX_ADDR'(i_read_addr), LANE_BITS, IDX_W));
   assign fe_idx = idx_t'(word_index(RAM_MAX_ADDR'(i_fetch_addr), LANE_BITS, IDX_W));
   assign wr_idx = idx_t'(word_index(RAM_MAX_ADDR'(i_write_addr), LANE_BITS, IDX_W));

   assign clearing = (state_q == RAM_CLEAR);
   assign o_ready  = (state_q == RAM_READY);
   assign clear_go = clearing & clk_en & ~rst;
   assign accept   = o_ready & clk_en & ~rst;
   assign wr_go    = accept & i_write_enable;
   assign rd_go    = accept & i_read_req;
   assign fe_go    = accept & i_fetch_req;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= RAM_CLEAR;
         cnt_q   <= '0;
      end else if (clk_en) begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (state_q == RAM_CLEAR) begin
         cnt_d = cnt_q + idx_t'(1);
         if (cnt_q == idx_t'(DEPTH - 1)) state_d = RAM_READY;
      end
   end

   // The clear sequencer borrows the single write port while requests are blocked.
   assign lane_waddr = clearing ? cnt_q : wr_idx;
   assign lane_wdata = clearing ? '0 : i_write_data;
   assign lane_we    = clear_go ? {NUM_LANES{1'b1}} : (wr_go ? i_byte_enable : '0);

   for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
      ram_lane #(.DEPTH(DEPTH)) u_lane (
         .clk       (clk),
         .we_i      (lane_we[k]),
         .waddr_i   (lane_waddr),
         .wdata_i   (lane_wdata[8*k +: 8]),
         .re_i      (clk_en),
         .raddr_a_i (rd_idx),
         .raddr_b_i (fe_idx),
         .rdata_a_o (raw_rd[8*k +: 8]),
         .rdata_b_o (raw_fe[8*k +: 8])
      );
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rvalid_q   <= 1'b0;
         fvalid_q   <= 1'b0;
         rhit_q     <= 1'b0;
         fhit_q     <= 1'b0;
         fwd_data_q <= '0;
         fwd_be_q   <= '0;
      end else if (clk_en) begin
         rvalid_q   <= rd_go;
         fvalid_q   <= fe_go;
         rhit_q     <= wr_go & (wr_idx == rd_idx);
         fhit_q     <= wr_go & (wr_idx == fe_idx);
         fwd_data_q <= i_write_data;
         fwd_be_q   <= i_byte_enable;
      end
   end

   assign merged_rd = DATA_WIDTH'(merge_bytes(RAM_MAX_DATA'(raw_rd), RAM_MAX_DATA'(fwd_data_q),
                                              RAM_MAX_LANES'(fwd_be_q)));
   assign merged_fe = DATA_WIDTH'(merge_bytes(RAM_MAX_DATA'(raw_fe), RAM_MAX_DATA'(fwd_data_q),
                                              RAM_MAX_LANES'(fwd_be_q)));

   assign o_read_valid  = rvalid_q;
   assign o_fetch_valid = fvalid_q;
   assign o_read_data   = rvalid_q ? (rhit_q ? merged_rd : raw_rd) : '0;
   assign o_fetch_data  = fvalid_q ? (fhit_q ? merged_fe : raw_fe) : '0;

endmodule

// File: tb/tb_ram_banked_sync.sv
// Directed bench for ram_banked_sync (DEPTH=16): a behavioural model pushes the
// expected outputs of every edge into a queue, popped and compared just after the edge.
module tb_ram_banked_sync;

   localparam int AW    = 32;
   localparam int DW    = 32;
   localparam int DEPTH = 16;
   localparam int NL    = DW / 8;

   logic          clk = 1'b0;
   logic          rst, clk_en, o_ready;
   logic          i_read_req, o_read_valid;
   logic [AW-1:0] i_read_addr;
   logic [DW-1:0] o_read_data;
   logic          i_fetch_req, o_fetch_valid;
   logic [AW-1:0] i_fetch_addr;
   logic [DW-1:0] o_fetch_data;
   logic          i_write_enable;
   logic [NL-1:0] i_byte_enable;
   logic [AW-1:0] i_write_addr;
   logic [DW-1:0] i_write_data;

   always #5 clk = ~clk;

   ram_banked_sync #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
      .clk            (clk),
      .rst            (rst),
      .clk_en         (clk_en),
      .o_ready        (o_ready),
      .i_read_req     (i_read_req),
      .i_read_addr    (i_read_addr),
      .o_read_valid   (o_read_valid),
      .o_read_data    (o_read_data),
      .i_fetch_req    (i_fetch_req),
      .i_fetch_addr   (i_fetch_addr),
      .o_fetch_valid  (o_fetch_valid),
      .o_fetch_data   (o_fetch_data),
      .i_write_enable (i_write_enable),
      .i_byte_enable  (i_byte_enable),
      .i_write_addr   (i_write_addr),
      .i_write_data   (i_write_data)
   );

   typedef struct packed {
      logic          rdy;
      logic          rv;
      logic [DW-1:0] rd;
      logic          fv;
      logic [DW-1:0] fd;
   } exp_t;

   exp_t          exp_q[$];
   exp_t          m_out;
   logic [DW-1:0] m_mem [DEPTH];
   int            m_cnt;
   logic          m_ready;
   int            total = 0;
   int            bad   = 0;

   function automatic logic [DW-1:0] mrg(input logic [DW-1:0] old_w, input logic [DW-1:0] new_w,
                                         input logic [NL-1:0] be);
      logic [DW-1:0] r;
      r = old_w;
      for (int k = 0; k < NL; k++) if (be[k]) r[8*k +: 8] = new_w[8*k +: 8];
      return r;
   endfunction

   function automatic int widx(input logic [AW-1:0] a);
      return int'((a >> 2) & 32'hF);
   endfunction

   task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   task automatic step(input logic ce, input logic rs,
                       input logic rq, input logic [AW-1:0] ra,
                       input logic fq, input logic [AW-1:0] fa,
                       input logic we, input logic [NL-1:0] be,
                       input logic [AW-1:0] wa, input logic [DW-1:0] wd);
      exp_t          e;
      logic [DW-1:0] old_r, old_f;
      @(negedge clk);
      clk_en = ce; rst = rs;
      i_read_req = rq; i_read_addr = ra;
      i_fetch_req = fq; i_fetch_addr = fa;
      i_write_enable = we; i_byte_enable = be;
      i_write_addr = wa; i_write_data = wd;
      if (rs) begin
         m_ready = 1'b0;
         m_cnt   = 0;
         m_out   = '0;
      end else if (ce) begin
         if (!m_ready) begin
            m_mem[m_cnt] = '0;
            m_cnt++;
            if (m_cnt == DEPTH) m_ready = 1'b1;
            m_out = '0;
         end else begin
            old_r    = m_mem[widx(ra)];
            old_f    = m_mem[widx(fa)];
            if (we && widx(wa) == widx(ra)) old_r = mrg(old_r, wd, be);
            if (we && widx(wa) == widx(fa)) old_f = mrg(old_f, wd, be);
            m_out.rv = rq;
            m_out.rd = rq ? old_r : '0;
            m_out.fv = fq;
            m_out.fd = fq ? old_f : '0;
            if (we) m_mem[widx(wa)] = mrg(m_mem[widx(wa)], wd, be);
         end
      end
      m_out.rdy = m_ready;
      exp_q.push_back(m_out);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      check("ready",       DW'(o_ready),       DW'(e.rdy));
      check("read_valid",  DW'(o_read_valid),  DW'(e.rv));
      check("read_data",   o_read_data,        e.rd);
      check("fetch_valid", DW'(o_fetch_valid), DW'(e.fv));
      check("fetch_data",  o_fetch_data,       e.fd);
   endtask

   task automatic idle(input logic ce);
      step(ce, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0, '0, '0, '0);
   endtask

   task automatic rd2(input logic [AW-1:0] ra, input logic [AW-1:0] fa);
      step(1'b1, 1'b0, 1'b1, ra, 1'b1, fa, 1'b0, '0, '0, '0);
   endtask

   task automatic wr(input logic [AW-1:0] wa, input logic [DW-1:0] wd, input logic [NL-1:0] be);
      step(1'b1, 1'b0, 1'b0, '0, 1'b0, '0, 1'b1, be, wa, wd);
   endtask

   initial begin
      int n;
      rst = 1'b1; clk_en = 1'b1;
      i_read_req = 1'b0; i_read_addr = '0;
      i_fetch_req = 1'b0; i_fetch_addr = '0;
      i_write_enable = 1'b0; i_byte_enable = '0;
      i_write_addr = '0; i_write_data = '0;
      m_ready = 1'b0; m_cnt = 0; m_out = '0;

      step(1'b1, 1'b1, 1'b0, '0, 1'b0, '0, 1'b0, '0, '0, '0);
      step(1'b1, 1'b1, 1'b1, 32'h3C, 1'b1, 32'h3C, 1'b0, '0, '0, '0);

      n = 0;
      for (int i = 0; i < 40; i++) begin
         idle(1'b1);
         n++;
         if (o_ready) break;
      end
      check("ready_latency", DW'(n), DW'(16));

      rd2(32'h3C, 32'h3C);
      check("clear_word_15", o_read_data, 32'h0);
      idle(1'b1);

      wr(32'h10, 32'hDEADBEEF, 4'b1111);
      rd2(32'h10, 32'h10);
      check("full_write_rd", o_read_data, 32'hDEADBEEF);
      check("full_write_fe", o_fetch_data, 32'hDEADBEEF);

      wr(32'h10, 32'h11223344, 4'b0101);
      rd2(32'h10, 32'h14);
      check("partial_write", o_read_data, 32'hDE22BE44);

      wr(32'h10, 32'hDEADBEEF, 4'b1111);
      step(1'b1, 1'b0, 1'b1, 32'h10, 1'b1, 32'h12, 1'b1, 4'b0011, 32'h10, 32'hCAFEF00D);
      check("fwd_rd", o_read_data, 32'hDEADF00D);
      check("fwd_fe", o_fetch_data, 32'hDEADF00D);
      rd2(32'h10, 32'h3C);
      check("after_fwd", o_read_data, 32'hDEADF00D);

      wr(32'h10, 32'h55555555, 4'b0000);
      rd2(32'h10, 32'h10);

      wr(32'h42, 32'hA5A5A5A5, 4'b1111);
      rd2(32'h40, 32'h02);
      check("wrap_rd", o_read_data, 32'hA5A5A5A5);
      check("wrap_fe", o_fetch_data, 32'hA5A5A5A5);

      rd2(32'h10, 32'h40);
      for (int i = 0; i < 3; i++)
         step(1'b0, 1'b0, 1'b1, 32'h40, 1'b1, 32'h10, 1'b1, 4'b1111, 32'h10, 32'h12345678);
      check("stall_hold", o_read_data, 32'hDEADF00D);
      rd2(32'h10, 32'h00);
      check("stall_no_write", o_read_data, 32'hDEADF00D);

      step(1'b1, 1'b1, 1'b0, '0, 1'b0, '0, 1'b0, '0, '0, '0);
      for (int i = 0; i < 7; i++) idle(1'b1);
      step(1'b0, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0, '0, '0, '0);
      step(1'b1, 1'b1, 1'b0, '0, 1'b0, '0, 1'b0, '0, '0, '0);

      n = 0;
      for (int i = 0; i < 40; i++) begin
         step(1'b1, 1'b0, 1'b1, 32'h10, 1'b1, 32'h10, (i == 0), 4'b1111, 32'h10, 32'hFFFFFFFF);
         n++;
         if (o_ready) break;
      end
      check("reclear_latency", DW'(n), DW'(16));

      rd2(32'h10, 32'h40);
      check("dropped_write", o_read_data, 32'h0);
      check("reclear_fe", o_fetch_data, 32'h0);
      idle(1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "bench timeout");
   end

endmodule
